// File: rtl/qbu_tx_dispatch_if.sv
// Stream bundle for qbu_tx_dispatch: one input stream and the express
// (emac) and preemptable (pmac) output streams. The signal names match the
// block's port names, so each one reads the same at both ends.
interface qbu_tx_dispatch_if #(
  parameter int DWIDTH = 8
) ();
  localparam int KW = DWIDTH / 8;

  // input stream
  logic [DWIDTH-1:0] i_qbu_tx_axis_data;
  logic [15:0]       i_qbu_tx_axis_user;
  logic [KW-1:0]     i_qbu_tx_axis_keep;
  logic              i_qbu_tx_axis_last;
  logic              i_qbu_tx_axis_valid;
  logic              o_qbu_tx_axis_ready;

  // express output stream
  logic [DWIDTH-1:0] o_emac_axis_data;
  logic [15:0]       o_emac_axis_user;
  logic [KW-1:0]     o_emac_axis_keep;
  logic              o_emac_axis_last;
  logic              o_emac_axis_valid;
  logic              i_emac_axis_ready;

  // preemptable output stream
  logic [DWIDTH-1:0] o_pmac_axis_data;
  logic [15:0]       o_pmac_axis_user;
  logic [KW-1:0]     o_pmac_axis_keep;
  logic              o_pmac_axis_last;
  logic              o_pmac_axis_valid;
  logic              i_pmac_axis_ready;

  // Source side: drives the input stream and the downstream readies.
  modport master (
    output i_qbu_tx_axis_data, i_qbu_tx_axis_user, i_qbu_tx_axis_keep,
    output i_qbu_tx_axis_last, i_qbu_tx_axis_valid,
    input  o_qbu_tx_axis_ready,
    input  o_emac_axis_data, o_emac_axis_user, o_emac_axis_keep,
    input  o_emac_axis_last, o_emac_axis_valid,
    output i_emac_axis_ready,
    input  o_pmac_axis_data, o_pmac_axis_user, o_pmac_axis_keep,
    input  o_pmac_axis_last, o_pmac_axis_valid,
    output i_pmac_axis_ready
  );

  // Dispatcher side.
  modport slave (
    input  i_qbu_tx_axis_data, i_qbu_tx_axis_user, i_qbu_tx_axis_keep,
    input  i_qbu_tx_axis_last, i_qbu_tx_axis_valid,
    output o_qbu_tx_axis_ready,
    output o_emac_axis_data, o_emac_axis_user, o_emac_axis_keep,
    output o_emac_axis_last, o_emac_axis_valid,
    input  i_emac_axis_ready,
    output o_pmac_axis_data, o_pmac_axis_user, o_pmac_axis_keep,
    output o_pmac_axis_last, o_pmac_axis_valid,
    input  i_pmac_axis_ready
  );
endinterface

// File: rtl/qbu_tx_dispatch.sv
// qbu_tx_dispatch: steers each frame of the transmit stream to the express
// (emac) or preemptable (pmac) MAC. The decision is taken on the first beat
// and then held for the whole frame. Each output has a one-entry register
// slice, so a beat appears one cycle after acceptance and runs at full rate.
module qbu_tx_dispatch #(
  parameter int DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  qbu_tx_dispatch_if.slave  bus,
  input  logic              i_pmac_en,
  output logic              o_wr_emac_info,
  output logic              o_wr_pmac_info,
  output logic [15:0]       o_emac_frm_cnt,
  output logic [15:0]       o_pmac_frm_cnt
);
  localparam int KW = DWIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMAC = 2'd1,
    ST_PMAC = 2'd2
  } state_t;

  state_t state_q, state_d;
  state_t sel_s;
  logic   valid_sel_s, ready_sel_s, in_ready_s, accept_s;
  logic   load_e_s, load_p_s;

  logic              e_valid_q, e_valid_d, e_last_q, e_last_d;
  logic [DWIDTH-1:0] e_data_q, e_data_d;
  logic [15:0]       e_user_q, e_user_d;
  logic [KW-1:0]     e_keep_q, e_keep_d;
  logic              p_valid_q, p_valid_d, p_last_q, p_last_d;
  logic [DWIDTH-1:0] p_data_q, p_data_d;
  logic [15:0]       p_user_q, p_user_d;
  logic [KW-1:0]     p_keep_q, p_keep_d;
  logic              e_info_q, e_info_d, p_info_q, p_info_d;
  logic [15:0]       e_cnt_q, e_cnt_d, p_cnt_q, p_cnt_d;

  // Route selection, input handshake and next-state for every register.
  always_comb begin
    if (state_q == ST_IDLE) begin
      if (bus.i_qbu_tx_axis_user[15] || !i_pmac_en) begin
        sel_s = ST_EMAC;
      end else begin
        sel_s = ST_PMAC;
      end
    end else begin
      sel_s = state_q;
    end

    if (sel_s == ST_EMAC) begin
      valid_sel_s = e_valid_q;
      ready_sel_s = bus.i_emac_axis_ready;
    end else begin
      valid_sel_s = p_valid_q;
      ready_sel_s = bus.i_pmac_axis_ready;
    end

    // Ready is forced low while reset is asserted.
    in_ready_s = !i_rst && (!valid_sel_s || ready_sel_s);
    accept_s   = bus.i_qbu_tx_axis_valid && in_ready_s;
    load_e_s   = accept_s && (sel_s == ST_EMAC);
    load_p_s   = accept_s && (sel_s == ST_PMAC);

    state_d   = state_q;
    e_valid_d = e_valid_q;
    e_last_d  = e_last_q;
    e_data_d  = e_data_q;
    e_user_d  = e_user_q;
    e_keep_d  = e_keep_q;
    p_valid_d = p_valid_q;
    p_last_d  = p_last_q;
    p_data_d  = p_data_q;
    p_user_d  = p_user_q;
    p_keep_d  = p_keep_q;
    e_cnt_d   = e_cnt_q;
    p_cnt_d   = p_cnt_q;

    // A frame stays on its channel until its last beat is accepted.
    if (accept_s) begin
      if (bus.i_qbu_tx_axis_last) begin
        state_d = ST_IDLE;
      end else begin
        state_d = sel_s;
      end
    end else begin
      state_d = state_q;
    end

    // Express slice: load on acceptance, otherwise drain when taken.
    if (load_e_s) begin
      e_valid_d = 1'b1;
      e_last_d  = bus.i_qbu_tx_axis_last;
      e_data_d  = bus.i_qbu_tx_axis_data;
      e_user_d  = {1'b0, bus.i_qbu_tx_axis_user[14:0]};
      e_keep_d  = bus.i_qbu_tx_axis_keep;
    end else if (bus.i_emac_axis_ready) begin
      e_valid_d = 1'b0;
    end else begin
      e_valid_d = e_valid_q;
    end

    // Preemptable slice: same policy as the express slice.
    if (load_p_s) begin
      p_valid_d = 1'b1;
      p_last_d  = bus.i_qbu_tx_axis_last;
      p_data_d  = bus.i_qbu_tx_axis_data;
      p_user_d  = {1'b0, bus.i_qbu_tx_axis_user[14:0]};
      p_keep_d  = bus.i_qbu_tx_axis_keep;
    end else if (bus.i_pmac_axis_ready) begin
      p_valid_d = 1'b0;
    end else begin
      p_valid_d = p_valid_q;
    end

    // Frame-start pulses: first beat is the one accepted while IDLE.
    e_info_d = load_e_s && (state_q == ST_IDLE);
    p_info_d = load_p_s && (state_q == ST_IDLE);

    // Frame counters advance on each accepted last beat and wrap naturally.
    if (load_e_s && bus.i_qbu_tx_axis_last) begin
      e_cnt_d = e_cnt_q + 16'd1;
    end else begin
      e_cnt_d = e_cnt_q;
    end
    if (load_p_s && bus.i_qbu_tx_axis_last) begin
      p_cnt_d = p_cnt_q + 16'd1;
    end else begin
      p_cnt_d = p_cnt_q;
    end
  end

  // State, output slices, pulses and counters; synchronous reset clears all.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      e_valid_q <= 1'b0;
      e_last_q  <= 1'b0;
      e_data_q  <= '0;
      e_user_q  <= 16'd0;
      e_keep_q  <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_data_q  <= '0;
      p_user_q  <= 16'd0;
      p_keep_q  <= '0;
      e_info_q  <= 1'b0;
      p_info_q  <= 1'b0;
      e_cnt_q   <= 16'd0;
      p_cnt_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      e_valid_q <= e_valid_d;
      e_last_q  <= e_last_d;
      e_data_q  <= e_data_d;
      e_user_q  <= e_user_d;
      e_keep_q  <= e_keep_d;
      p_valid_q <= p_valid_d;
      p_last_q  <= p_last_d;
      p_data_q  <= p_data_d;
      p_user_q  <= p_user_d;
      p_keep_q  <= p_keep_d;
      e_info_q  <= e_info_d;
      p_info_q  <= p_info_d;
      e_cnt_q   <= e_cnt_d;
      p_cnt_q   <= p_cnt_d;
    end
  end

  assign bus.o_qbu_tx_axis_ready = in_ready_s;
  assign bus.o_emac_axis_valid   = e_valid_q;
  assign bus.o_emac_axis_last    = e_last_q;
  assign bus.o_emac_axis_data    = e_data_q;
  assign bus.o_emac_axis_user    = e_user_q;
  assign bus.o_emac_axis_keep    = e_keep_q;
  assign bus.o_pmac_axis_valid   = p_valid_q;
  assign bus.o_pmac_axis_last    = p_last_q;
  assign bus.o_pmac_axis_data    = p_data_q;
  assign bus.o_pmac_axis_user    = p_user_q;
  assign bus.o_pmac_axis_keep    = p_keep_q;
  assign o_wr_emac_info          = e_info_q;
  assign o_wr_pmac_info          = p_info_q;
  assign o_emac_frm_cnt          = e_cnt_q;
  assign o_pmac_frm_cnt          = p_cnt_q;

endmodule

// File: doc/qbu_tx_dispatch.md
QBU_TX_DISPATCH -- requirements
Module: qbu_tx_dispatch

Interface
REQ-001 The block SHALL have a parameter DWIDTH, default 8, giving the stream data width in bits; the keep width is DWIDTH/8.
REQ-002 The block SHALL have these ports: i_clk, input, 1, the single clock; the block has one clock, and all logic is on its rising edge.
REQ-003 The block SHALL have these ports: i_rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have the input stream ports: i_qbu_tx_axis_data in DWIDTH; i_qbu_tx_axis_user in 16 (bit 15: 1=express, 0=preemptable); i_qbu_tx_axis_keep in DWIDTH/8; i_qbu_tx_axis_last in 1; i_qbu_tx_axis_valid in 1; o_qbu_tx_axis_ready out 1.
REQ-005 The block SHALL have the express output ports: o_emac_axis_data out DWIDTH; o_emac_axis_user out 16; o_emac_axis_keep out DWIDTH/8; o_emac_axis_last out 1; o_emac_axis_valid out 1; i_emac_axis_ready in 1.
REQ-006 The block SHALL have the preemptable output ports: o_pmac_axis_data, o_pmac_axis_user, o_pmac_axis_keep, o_pmac_axis_last and o_pmac_axis_valid as outputs, and i_pmac_axis_ready as an input, with the same widths as REQ-005.
REQ-007 The block SHALL have these ports: i_pmac_en, input, 1, preemption enable; o_wr_emac_info, output, 1, frame-start pulse on the express path; o_wr_pmac_info, output, 1, frame-start pulse on the preemptable path; o_emac_frm_cnt, output, 16, count of express frames; o_pmac_frm_cnt, output, 16, count of preemptable frames.

Function
REQ-008 The block SHALL have the states IDLE, EMAC and PMAC; the state is a registered value.
REQ-009 A beat SHALL be accepted when i_qbu_tx_axis_valid and o_qbu_tx_axis_ready are both 1.
REQ-010 The route selection sel SHALL be: in IDLE, sel = EMAC if (i_qbu_tx_axis_user[15] OR NOT i_pmac_en), else PMAC; in EMAC or PMAC, sel = the current state.
REQ-011 The routing decision SHALL be made only on the first beat of a frame; changes to i_pmac_en or user[15] in the middle of a frame SHALL be ignored.
REQ-012 Each output SHALL have a one-entry register slice; o_qbu_tx_axis_ready SHALL equal (NOT valid_sel OR ready_sel), where valid_sel and ready_sel are the output valid and the downstream ready of the sel channel.
REQ-013 The non-selected output SHALL never load.
REQ-014 An accepted beat SHALL appear on the sel output on the next cycle: latency 1 cycle, with data, keep and last passed unchanged.
REQ-015 Each output user SHALL be {1'b0, i_qbu_tx_axis_user[14:0]}, so bit 15 is cleared on egress.
REQ-016 An output valid SHALL be held, with its data stable, until that output's ready is 1.
REQ-017 The output slice SHALL sustain full throughput: one beat per cycle when downstream ready is held at 1.
REQ-018 State transitions SHALL be as follows:
- IDLE -> sel on an accepted beat with last = 0.
- IDLE stays IDLE on an accepted single-beat frame (last = 1).
- EMAC or PMAC -> IDLE on an accepted beat with last = 1; all other cycles hold the state.
REQ-019 Back-to-back frames SHALL be accepted with no bubble cycle: the first beat of a frame may be accepted in the cycle after the previous frame's last beat.
REQ-020 o_wr_emac_info or o_wr_pmac_info SHALL pulse high for exactly 1 cycle, in the cycle after the first beat of a frame is accepted, on the sel channel.
REQ-021 o_emac_frm_cnt or o_pmac_frm_cnt SHALL increment by 1 in the cycle after the last beat of a frame is accepted on its channel, and SHALL wrap from 0xFFFF to 0x0000.
REQ-022 When i_qbu_tx_axis_valid = 0, the block SHALL not change state, accept nothing and change neither counter.
REQ-023 A PMAC frame in progress SHALL complete on PMAC even if an express frame is waiting; this block does not itself preempt.

Reset
REQ-024 While i_rst = 1 on a rising edge of i_clk: the state SHALL become IDLE; all output valid, last, data, user and keep SHALL become 0; the info pulses SHALL become 0; and both counters SHALL become 0.
REQ-025 o_qbu_tx_axis_ready SHALL be 0 during any cycle in which i_rst = 1.
REQ-026 A reset in the middle of a frame SHALL discard the partial frame and the output slices; the first valid beat after reset is treated as a frame start.

Verification
REQ-027 Scenario 1: a 64-beat frame with user = 0x8005 and all ready = 1 -> o_emac carries 64 beats, each with user 0x0005 and latency 1; o_wr_emac_info pulses once; o_emac_frm_cnt = 1; o_pmac_axis_valid never goes high.
REQ-028 Scenario 2: i_pmac_en = 1, with a frame of user 0x0003 followed back-to-back by a frame of user 0x8003 -> PMAC frame then EMAC frame with no idle cycle on the input; each counter = 1.
REQ-029 Scenario 3: i_pmac_en = 0 with a frame of user 0x0001 -> the frame is routed to EMAC; o_pmac_frm_cnt stays 0.
REQ-030 Scenario 4: i_pmac_axis_ready = 0 for 5 cycles in the middle of a PMAC frame -> o_qbu_tx_axis_ready = 0; the output beat is held stable; no beat is lost or duplicated.
REQ-031 Scenario 5: i_pmac_en toggled and user[15] toggled in the middle of a frame -> routing is unchanged until the last beat.
REQ-032 Scenario 6: i_rst = 1 for 1 cycle after beat 10 of a 20-beat frame, then a new frame is sent -> all outputs are 0 during the reset cycle; the new frame is routed by its own user[15]; the counters restart from 0.
REQ-033 Scenario 7: 65537 single-beat EMAC frames -> o_emac_frm_cnt = 1.
